// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - control FSM for a bit-serial adder datapath
module serial_add_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum_out,
    output logic [WIDTH-1:0] dp_a,
    output logic [WIDTH-1:0] dp_b,
    output logic             dp_load,
    output logic             dp_shift,
    output logic             dp_carry_clr,
    input  logic [WIDTH-1:0] dp_sum
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dp_a_q, dp_a_d;
    logic [WIDTH-1:0] dp_b_q, dp_b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             done_q, done_d;
    // High only in the cycle following a reset edge, so the carry flop is cleared there too.
    logic             rst_cyc_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dp_a_q    <= '0;
            dp_b_q    <= '0;
            sum_q     <= '0;
            done_q    <= 1'b0;
            rst_cyc_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dp_a_q    <= dp_a_d;
            dp_b_q    <= dp_b_d;
            sum_q     <= sum_d;
            done_q    <= done_d;
            rst_cyc_q <= 1'b0;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dp_a_d  = dp_a_q;
        dp_b_d  = dp_b_q;
        sum_d   = sum_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dp_a_d  = a_in;
                    dp_b_d  = b_in;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_SHIFT;
            end
            S_SHIFT: begin
                if (cnt_q == LAST_BIT) begin
                    cnt_d   = '0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                sum_d   = dp_sum;
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ready        = (state_q == S_IDLE);
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign sum_out      = sum_q;
    assign dp_a         = dp_a_q;
    assign dp_b         = dp_b_q;
    assign dp_load      = (state_q == S_LOAD);
    assign dp_shift     = (state_q == S_SHIFT);
    assign dp_carry_clr = (state_q == S_LOAD) || rst_cyc_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl at WIDTH 4 and 8
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       start4, start8;
    logic [3:0] a4, b4, sum_out4, dp_a4, dp_b4, dp_sum4;
    logic [7:0] a8, b8, sum_out8, dp_a8, dp_b8, dp_sum8;
    logic ready4, busy4, done4, dp_load4, dp_shift4, dp_carry_clr4;
    logic ready8, busy8, done8, dp_load8, dp_shift8, dp_carry_clr8;

    serial_add_ctrl #(.WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset), .start(start4), .a_in(a4), .b_in(b4),
        .ready(ready4), .busy(busy4), .done(done4), .sum_out(sum_out4),
        .dp_a(dp_a4), .dp_b(dp_b4), .dp_load(dp_load4), .dp_shift(dp_shift4),
        .dp_carry_clr(dp_carry_clr4), .dp_sum(dp_sum4)
    );

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(start8), .a_in(a8), .b_in(b8),
        .ready(ready8), .busy(busy8), .done(done8), .sum_out(sum_out8),
        .dp_a(dp_a8), .dp_b(dp_b8), .dp_load(dp_load8), .dp_shift(dp_shift8),
        .dp_carry_clr(dp_carry_clr8), .dp_sum(dp_sum8)
    );

    // Behavioural bit-serial datapaths driven by the controllers
    logic [3:0] sa4 = '0, sb4 = '0, ss4 = '0;
    logic [7:0] sa8 = '0, sb8 = '0, ss8 = '0;
    logic       c4 = 1'b0, c8 = 1'b0;
    assign dp_sum4 = ss4;
    assign dp_sum8 = ss8;

    always @(posedge clk) begin
        if (dp_load4) begin
            sa4 <= dp_a4;
            sb4 <= dp_b4;
        end else if (dp_shift4) begin
            sa4 <= sa4 >> 1;
            sb4 <= sb4 >> 1;
            ss4 <= {sa4[0] ^ sb4[0] ^ c4, ss4[3:1]};
        end
        if (dp_carry_clr4) c4 <= 1'b0;
        else if (dp_shift4) c4 <= (sa4[0] & sb4[0]) | (c4 & (sa4[0] ^ sb4[0]));
    end

    always @(posedge clk) begin
        if (dp_load8) begin
            sa8 <= dp_a8;
            sb8 <= dp_b8;
        end else if (dp_shift8) begin
            sa8 <= sa8 >> 1;
            sb8 <= sb8 >> 1;
            ss8 <= {sa8[0] ^ sb8[0] ^ c8, ss8[7:1]};
        end
        if (dp_carry_clr8) c8 <= 1'b0;
        else if (dp_shift8) c8 <= (sa8[0] & sb8[0]) | (c8 & (sa8[0] ^ sb8[0]));
    end

    int checks = 0;
    int errors = 0;
    logic [7:0] last_sum4, last_sum8;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       w8;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
        logic       poke;
    } vec_t;

    task automatic run_add(input string nm, input logic w8, input logic [7:0] a,
                           input logic [7:0] b, input logic [7:0] exp, input logic poke);
        int load_n = 0, shift_n = 0, done_n = 0, done_at = 0;
        int w = w8 ? 8 : 4;
        logic ld, sh, dn;
        logic [7:0] s;
        @(negedge clk);
        chk({nm, " ready_pre"}, w8 ? ready8 : ready4, 1);
        if (w8) begin a8 = a; b8 = b; start8 = 1'b1; end
        else begin a4 = a[3:0]; b4 = b[3:0]; start4 = 1'b1; end
        @(negedge clk);
        start4 = 1'b0;
        start8 = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            ld = w8 ? dp_load8 : dp_load4;
            sh = w8 ? dp_shift8 : dp_shift4;
            dn = w8 ? done8 : done4;
            s  = w8 ? sum_out8 : {4'h0, sum_out4};
            if (i == 1) chk({nm, " sum_hold"}, s, w8 ? last_sum8 : last_sum4);
            if (ld) load_n++;
            if (sh) shift_n++;
            if (dn) begin
                done_n++;
                if (done_at == 0) begin
                    done_at = i;
                    chk({nm, " sum"}, s, exp);
                end
            end
            if (poke && i == 3) begin
                if (w8) begin a8 = ~a; start8 = 1'b1; end
                else begin a4 = ~a[3:0]; start4 = 1'b1; end
            end
            if (i == 4) begin
                start4 = 1'b0;
                start8 = 1'b0;
            end
            if (done_at != 0 && i == done_at + 1) break;
            @(negedge clk);
        end
        chk({nm, " load_cycles"}, load_n, 1);
        chk({nm, " shift_cycles"}, shift_n, w);
        chk({nm, " done_index"}, done_at, w + 3);
        chk({nm, " done_width"}, done_n, 1);
        chk({nm, " dp_a"}, w8 ? dp_a8 : {4'h0, dp_a4}, w8 ? a : {4'h0, a[3:0]});
        chk({nm, " dp_b"}, w8 ? dp_b8 : {4'h0, dp_b4}, w8 ? b : {4'h0, b[3:0]});
        chk({nm, " ready_post"}, w8 ? ready8 : ready4, 1);
        if (w8) last_sum8 = exp;
        else last_sum4 = exp;
    endtask

    vec_t vecs[8];
    int   done_pos[3];
    int   dcount;

    initial begin
        vecs[0] = '{w8: 1'b0, a: 8'h03, b: 8'h05, exp: 8'h08, poke: 1'b0};
        vecs[1] = '{w8: 1'b0, a: 8'h0F, b: 8'h01, exp: 8'h00, poke: 1'b0};
        vecs[2] = '{w8: 1'b0, a: 8'h00, b: 8'h00, exp: 8'h00, poke: 1'b0};
        vecs[3] = '{w8: 1'b0, a: 8'h09, b: 8'h09, exp: 8'h02, poke: 1'b1};
        vecs[4] = '{w8: 1'b0, a: 8'h07, b: 8'h08, exp: 8'h0F, poke: 1'b0};
        vecs[5] = '{w8: 1'b1, a: 8'hA5, b: 8'h5B, exp: 8'h00, poke: 1'b0};
        vecs[6] = '{w8: 1'b1, a: 8'hFF, b: 8'hFF, exp: 8'hFE, poke: 1'b1};
        vecs[7] = '{w8: 1'b1, a: 8'h12, b: 8'h34, exp: 8'h46, poke: 1'b0};

        reset = 1'b0;
        start4 = 1'b1;
        start8 = 1'b0;
        a4 = 4'h9; b4 = 4'h9; a8 = '0; b8 = '0;
        @(negedge clk);
        @(negedge clk);
        chk("rst ready", ready4, 1);
        chk("rst busy", busy4, 0);
        chk("rst done", done4, 0);
        chk("rst sum_out", sum_out4, 0);
        chk("rst dp_a", dp_a4, 0);
        chk("rst dp_b", dp_b4, 0);
        chk("rst carry_clr", dp_carry_clr4, 1);
        chk("rst dp_load", dp_load4, 0);
        chk("rst dp_shift", dp_shift4, 0);
        chk("rst sum_out8", sum_out8, 0);
        start4 = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("rel carry_clr", dp_carry_clr4, 0);
        chk("rel ready", ready4, 1);
        chk("rel busy", busy4, 0);
        last_sum4 = 8'h00;
        last_sum8 = 8'h00;

        for (int v = 0; v < 8; v++)
            run_add($sformatf("vec%0d", v), vecs[v].w8, vecs[v].a, vecs[v].b,
                    vecs[v].exp, vecs[v].poke);

        // start held high: one add every 7 cycles, accepted in each done cycle
        @(negedge clk);
        a4 = 4'h2; b4 = 4'h2; start4 = 1'b1;
        dcount = 0;
        for (int i = 1; i <= 21; i++) begin
            @(negedge clk);
            if (done4) begin
                if (dcount < 3) done_pos[dcount] = i;
                dcount++;
                chk($sformatf("b2b sum%0d", dcount), sum_out4, 4'h4);
            end
            if (i == 3) chk("b2b busy", busy4, 1);
        end
        start4 = 1'b0;
        chk("b2b done_count", dcount, 3);
        chk("b2b pos0", done_pos[0], 7);
        chk("b2b pos1", done_pos[1], 14);
        chk("b2b pos2", done_pos[2], 21);
        chk("b2b dp_a", dp_a4, 4'h2);
        @(negedge clk);
        chk("b2b no_extra", busy4, 0);

        // reset during the third SHIFT cycle
        a4 = 4'h1; b4 = 4'h2; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("mid in_shift", dp_shift4, 1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("mid ready", ready4, 1);
        chk("mid done", done4, 0);
        chk("mid sum_out", sum_out4, 0);
        chk("mid carry_clr", dp_carry_clr4, 1);
        dcount = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done4) dcount++;
        end
        chk("mid no_done", dcount, 0);
        last_sum4 = 8'h00;
        last_sum8 = 8'h00;
        run_add("post_rst", 1'b0, 8'h06, 8'h07, 8'h0D, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand/sum bit count; legal range 2..16.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-low reset, sampled on clk rising edge.
REQ-004 SHALL have port start  input  1  requester pulse; request an add of a_in + b_in.
REQ-005 SHALL have port a_in  input  WIDTH  operand A, sampled when start accepted.
REQ-006 SHALL have port b_in  input  WIDTH  operand B, sampled when start accepted.
REQ-007 SHALL have port ready  output  1  high when a start will be accepted (IDLE state).
REQ-008 SHALL have port busy  output  1  high in LOAD, SHIFT, DONE states.
REQ-009 SHALL have port done  output  1  one-cycle pulse; sum_out newly valid.
REQ-010 SHALL have port sum_out  output  WIDTH  registered result of the last completed add.
REQ-011 SHALL have port dp_a  output  WIDTH  held operand A to datapath parallel-load input.
REQ-012 SHALL have port dp_b  output  WIDTH  held operand B to datapath parallel-load input.
REQ-013 SHALL have port dp_load  output  1  datapath shift-register parallel load.
REQ-014 SHALL have port dp_shift  output  1  datapath shift enable (operand, carry and sum registers).
REQ-015 SHALL have port dp_carry_clr  output  1  forces datapath carry flop to 0.
REQ-016 SHALL have port dp_sum  input  WIDTH  datapath parallel sum register.

Function
REQ-017 SHALL implement FSM states IDLE, LOAD, SHIFT, DONE, with all outputs driven only from registers or state decode (no combinational path from inputs to outputs).
REQ-018 IDLE: ready=1, all dp_* controls 0; start=1 at an edge -> capture a_in/b_in into dp_a/dp_b, go to LOAD.
REQ-019 LOAD (exactly 1 cycle): dp_load=1, dp_carry_clr=1, dp_shift=0; bit counter cleared to 0; next state SHIFT.
REQ-020 SHIFT (exactly WIDTH cycles): dp_shift=1; counter increments each edge; at counter==WIDTH-1 next state DONE, counter returns to 0.
REQ-021 DONE (exactly 1 cycle): all dp_* controls 0; at exiting edge sum_out <= dp_sum, done <= 1; next state IDLE.
REQ-022 done SHALL be high exactly one cycle (first IDLE cycle after DONE), else 0.
REQ-023 Latency: start accepted at edge E -> done high during the cycle after edge E+WIDTH+2.
REQ-024 Sum SHALL be (a_in + b_in) mod 2^WIDTH; carry-out discarded, no overflow flag.
REQ-025 start while busy=1 SHALL be ignored (not queued); dp_a/dp_b unchanged.
REQ-026 start in the cycle done=1 (IDLE) SHALL be accepted; sum_out retains prior value until next DONE exit.
REQ-027 dp_a/dp_b SHALL be held stable from acceptance until the next accepted start.
REQ-028 sum_out SHALL change only on a DONE exit edge or reset.

Reset
REQ-029 reset=0 at an edge SHALL force IDLE, counter=0, dp_a=dp_b=0, sum_out=0, done=0, dp_load=dp_shift=0, dp_carry_clr=1 for that reset cycle only.
REQ-030 Reset mid-operation (LOAD/SHIFT/DONE) SHALL abort with no done pulse and sum_out=0; start asserted during reset ignored.
REQ-031 After reset release: ready=1 on first cycle, first start accepted normally.

Verification
REQ-032 WIDTH=4, reset, start with a=4'h3, b=4'h5 -> dp_load 1 cycle, dp_shift 4 cycles, done pulse 7 edges after accept, sum_out=4'h8.
REQ-033 a=4'hF, b=4'h1 -> sum_out=4'h0 (wrap); following a=4'h0, b=4'h0 -> sum_out=4'h0 (carry cleared by LOAD).
REQ-034 start held high continuously with a=4'h2, b=4'h2 -> one add per 7 cycles back-to-back, each done pulse 1 cycle, sum_out=4'h4; starts during busy ignored.
REQ-035 reset=0 during 3rd SHIFT cycle -> no done pulse, sum_out=0, ready=1 next cycle; new add a=4'h6, b=4'h7 -> sum_out=4'hD.
REQ-036 WIDTH=8, a=8'hA5, b=8'h5B -> dp_shift 8 cycles, done 11 edges after accept, sum_out=8'h00.
